msd_wgt_encoder: RTL and testbench

MSD_WGT_ENCODER -- requirements
Module: msd_wgt_encoder

---
 rtl/msd_wgt_encoder.sv | 92 +++++++++
 tb/tb_msd_wgt_encoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msd_wgt_encoder.sv
// Encodes signed weights as non-adjacent-form signed power-of-two digits,
// emitted LSB-first, one per consumer handshake, for a bit-serial multiplier lane.
module msd_wgt_encoder #(
  parameter int WGT_DW  = 8,
  parameter int IDX_DW  = 4,
  parameter int MAX_DIG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic signed [WGT_DW-1:0] w_data,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [IDX_DW-1:0]        d_idx,
  output logic                     d_last,
  output logic                     d_zero
);

  localparam int RW    = WGT_DW + 1;
  localparam int SW    = IDX_DW - 1;
  localparam int CNT_W = (MAX_DIG > 1) ? $clog2(MAX_DIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DIG - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                r_state;
  logic signed [RW-1:0]  r_res;
  logic [CNT_W-1:0]      r_cnt;

  logic [RW-1:0]         w_mask;
  logic                  w_neg;
  logic [SW-1:0]         w_shift;
  logic signed [RW-1:0]  w_res_nxt;
  logic                  w_res_zero;
  logic                  w_last_dig;
  logic                  w_w_acc;
  logic                  w_d_acc;

  function automatic logic [RW-1:0] lsb_isolate(input logic [RW-1:0] v);
    return v & (~v + 1'b1);
  endfunction

  function automatic logic [SW-1:0] onehot_to_shift(input logic [RW-1:0] oh);
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < WGT_DW; i++) begin
      if (oh[i]) s = SW'(i);
    end
    return s;
  endfunction

  // A run of ones starting at the lowest set bit is folded into a negative
  // digit plus a carry, which is what keeps the digit positions non-adjacent.
  assign w_mask     = lsb_isolate(r_res);
  assign w_neg      = |((w_mask << 1) & r_res);
  assign w_shift    = onehot_to_shift(w_mask);
  assign w_res_nxt  = w_neg ? (r_res + $signed(w_mask)) : (r_res - $signed(w_mask));
  assign w_res_zero = (r_res == '0);
  assign w_last_dig = w_res_zero | (w_res_nxt == '0) | (r_cnt == CNT_LAST);

  assign d_valid = (r_state == EMIT);
  assign d_idx   = (d_valid && !w_res_zero) ? {w_neg, w_shift} : '0;
  assign d_last  = d_valid & w_last_dig;
  assign d_zero  = d_valid & w_res_zero;

  assign w_ready = (r_state == IDLE) | (d_valid & d_ready & d_last);
  assign w_w_acc = w_valid & w_ready;
  assign w_d_acc = d_valid & d_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_res   <= '0;
      r_cnt   <= '0;
    end else if (w_w_acc) begin
      r_state <= EMIT;
      r_res   <= {w_data[WGT_DW-1], w_data};
      r_cnt   <= '0;
    end else if (w_d_acc) begin
      if (d_last) begin
        r_state <= IDLE;
        r_res   <= '0;
        r_cnt   <= '0;
      end else begin
        r_res   <= w_res_nxt;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_msd_wgt_encoder.sv
// Directed and random checks of msd_wgt_encoder with MAX_DIG = 4, 3 and 8.
module tb_msd_wgt_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [1:0]        sel;
  logic              w_valid;
  logic signed [7:0] w_data;
  logic              d_ready;

  logic       wv [3];
  logic       wr [3];
  logic       dv [3];
  logic [3:0] di [3];
  logic       dl [3];
  logic       dz [3];

  assign wv[0] = w_valid && (sel == 2'd0);
  assign wv[1] = w_valid && (sel == 2'd1);
  assign wv[2] = w_valid && (sel == 2'd2);

  msd_wgt_encoder #(.WGT_DW(8), .IDX_DW(4), .MAX_DIG(4)) dut (
    .clk(clk), .rst(rst), .w_valid(wv[0]), .w_ready(wr[0]), .w_data(w_data),
    .d_valid(dv[0]), .d_ready(d_ready), .d_idx(di[0]), .d_last(dl[0]), .d_zero(dz[0]));

  msd_wgt_encoder #(.WGT_DW(8), .IDX_DW(4), .MAX_DIG(3)) dut3 (
    .clk(clk), .rst(rst), .w_valid(wv[1]), .w_ready(wr[1]), .w_data(w_data),
    .d_valid(dv[1]), .d_ready(d_ready), .d_idx(di[1]), .d_last(dl[1]), .d_zero(dz[1]));

  msd_wgt_encoder #(.WGT_DW(8), .IDX_DW(4), .MAX_DIG(8)) dut8 (
    .clk(clk), .rst(rst), .w_valid(wv[2]), .w_ready(wr[2]), .w_data(w_data),
    .d_valid(dv[2]), .d_ready(d_ready), .d_idx(di[2]), .d_last(dl[2]), .d_zero(dz[2]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int         c0[$];
  int         exp8[$];
  int         s8, v8;
  int         acc8  = 0;
  int         prev8 = -1;

  // Digit capture for the MAX_DIG=4/3 instances and a NAF model check for MAX_DIG=8.
  always @(negedge clk) begin
    if (!rst && dv[0] && d_ready) begin
      q0.push_back({dz[0], dl[0], di[0]});
      c0.push_back(cyc);
    end
    if (!rst && dv[1] && d_ready) q1.push_back({dz[1], dl[1], di[1]});
    if (!rst && dv[2] && d_ready) begin
      s8 = int'(di[2][2:0]);
      v8 = dz[2] ? 0 : (di[2][3] ? -(1 << s8) : (1 << s8));
      if (!dz[2]) begin
        if (prev8 >= 0) chk("rnd_order_nonadj", int'(s8 > prev8 + 1), 1);
        prev8 = s8;
      end
      acc8 += v8;
      if (dl[2]) begin
        if (exp8.size() == 0) chk("rnd_unexpected_weight", 0, 1);
        else chk("rnd_sum", acc8, exp8.pop_front());
        acc8  = 0;
        prev8 = -1;
      end
    end
  end

  typedef struct {
    logic signed [7:0] w;
    int                n;
    logic [15:0]       idx;
  } vec_t;

  vec_t vecs[13];

  task automatic send(input int s, input logic signed [7:0] v);
    int t;
    t       = 0;
    sel     = 2'(s);
    w_data  = v;
    w_valid = 1'b1;
    @(negedge clk);
    while (!wr[s] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_w_ready", int'(wr[s]), 1);
    @(posedge clk);
    #1 w_valid = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    int t;
    t = 0;
    @(negedge clk);
    while (dv[s] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_d_valid", int'(dv[s]), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_seq(input int s, input string nm, input int n, input logic [15:0] ex,
                         input logic z);
    int         sz;
    logic [5:0] got;
    logic [5:0] want;
    sz = (s == 0) ? q0.size() : q1.size();
    chk({nm, "_count"}, sz, n);
    for (int k = 0; k < n && k < sz; k++) begin
      got  = (s == 0) ? q0[k] : q1[k];
      want = {z, (k == n - 1), ex[4*k +: 4]};
      chk($sformatf("%s_dig%0d", nm, k), int'(got), int'(want));
    end
  endtask

  logic signed [7:0] sw[3];
  logic [5:0]        st_exp[5];
  logic              acc;
  int                i, nw, t;

  initial begin
    vecs[0]  = '{8'sd0,    1, 16'h0000};
    vecs[1]  = '{8'sd7,    2, 16'h0038};
    vecs[2]  = '{8'sd127,  2, 16'h0078};
    vecs[3]  = '{-8'sd128, 1, 16'h000F};
    vecs[4]  = '{8'sd85,   4, 16'h6420};
    vecs[5]  = '{-8'sd1,   1, 16'h0008};
    vecs[6]  = '{8'sd1,    1, 16'h0000};
    vecs[7]  = '{-8'sd3,   2, 16'h00A0};
    vecs[8]  = '{8'sd3,    2, 16'h0028};
    vecs[9]  = '{8'sd100,  3, 16'h07D2};
    vecs[10] = '{-8'sd100, 3, 16'h0F5A};
    vecs[11] = '{-8'sd85,  4, 16'hECA8};
    vecs[12] = '{8'sd64,   1, 16'h0006};

    rst = 1'b1; sel = 2'd0; w_valid = 1'b0; w_data = '0; d_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_d_valid", int'(dv[0]), 0);
    chk("rst_d_idx",   int'(di[0]), 0);
    chk("rst_d_last",  int'(dl[0]), 0);
    chk("rst_d_zero",  int'(dz[0]), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_w_ready", int'(wr[0]), 1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 13; v++) begin
      q0.delete();
      send(0, vecs[v].w);
      wait_idle(0);
      cmp_seq(0, $sformatf("vec_w%0d", vecs[v].w), vecs[v].n, vecs[v].idx, vecs[v].w == 0);
    end

    q1.delete();
    send(1, 8'sd85);
    wait_idle(1);
    cmp_seq(1, "trunc3_w85", 3, 16'h0420, 1'b0);

    // Backpressure: stall on the second digit of 85.
    q0.delete();
    send(0, 8'sd85);
    @(posedge clk);
    #1 d_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_outputs", int'({dv[0], dz[0], dl[0], di[0]}), int'(7'b1_0_0_0010));
    end
    @(posedge clk);
    #1 d_ready = 1'b1;
    wait_idle(0);
    cmp_seq(0, "stall_w85", 4, 16'h6420, 1'b0);

    // Streaming 7, 0, -3 with no bubbles.
    q0.delete(); c0.delete();
    sw[0] = 8'sd7; sw[1] = 8'sd0; sw[2] = -8'sd3;
    st_exp[0] = 6'b0_0_1000; st_exp[1] = 6'b0_1_0011; st_exp[2] = 6'b1_1_0000;
    st_exp[3] = 6'b0_0_0000; st_exp[4] = 6'b0_1_1010;
    i = 0; sel = 2'd0; w_data = sw[0]; w_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (dv[0] && dl[0]) chk("stream_w_ready_on_last", int'(wr[0]), 1);
      if (!w_valid && !dv[0]) break;
      acc = w_valid && wr[0];
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        if (i < 3) w_data = sw[i];
        else w_valid = 1'b0;
      end
    end
    w_valid = 1'b0;
    chk("stream_count", q0.size(), 5);
    for (int k = 0; k < 5 && k < q0.size(); k++) begin
      chk($sformatf("stream_dig%0d", k), int'(q0[k]), int'(st_exp[k]));
      chk($sformatf("stream_cycle%0d", k), c0[k], c0[0] + k);
    end
    @(posedge clk);
    #1;

    // Reset during emission aborts the weight after its first digit.
    q0.delete();
    send(0, 8'sd85);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_d_valid", int'(dv[0]), 0);
    chk("abort_w_ready", int'(wr[0]), 1);
    repeat (4) @(negedge clk);
    chk("abort_digits", q0.size(), 1);
    @(posedge clk);
    #1;

    // Random stream into the MAX_DIG=8 instance with random backpressure.
    nw = 0; t = 0; sel = 2'd2;
    w_data  = 8'($urandom);
    w_valid = 1'b1;
    while (nw < 10000 && t < 60000) begin
      @(negedge clk);
      acc = w_valid && wr[2];
      if (acc) exp8.push_back(int'(w_data));
      @(posedge clk);
      #1;
      d_ready = ($urandom_range(0, 9) != 0);
      if (acc) begin
        nw++;
        w_data = 8'($urandom);
      end
      t++;
    end
    w_valid = 1'b0;
    d_ready = 1'b1;
    chk("rnd_weights_accepted", nw, 10000);
    wait_idle(2);
    chk("rnd_all_weights_done", exp8.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
